// File: rtl/axis_checker_pkg.sv
// Shared types and helpers for the AXI4-Stream pattern checker.
// Holds the FSM state type, error bit positions and the saturating add.
package axis_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ERR_DATA = 0;
  localparam int ERR_STRB = 1;
  localparam int ERR_LAST = 2;
  localparam int ERR_NUM  = 3;

  // value + inc, clamped to 2^width-1; width may be at most 32
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [1:0]  inc,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max_val;
    max_val = (33'(1) << width) - 33'(1);
    sum     = {1'b0, value} + {31'b0, inc};
    if (sum > max_val) sum = max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI4-Stream bus bundle between a beat source (master) and the checker (slave).
// A beat transfers on a rising clock edge where tvalid and tready are both 1;
// tdata/tstrb/tlast are only meaningful on that edge, and tready may depend
// on registered sink state but never on tvalid.
interface axis_stream_checker_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_checker_sat_counter.sv
// Status counter that adds 0..3 per cycle and sticks at its maximum value.
// CNT_WIDTH is limited to 32 bits by the shared saturating-add helper.
module axis_checker_sat_counter
  import axis_checker_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [1:0]           inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= CNT_WIDTH'(sat_inc(32'(count), inc, CNT_WIDTH));
    end
  end

endmodule

// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink that checks an incrementing data pattern and frame length,
// counts beats/frames/errors and signals done after NUM_FRAMES frames.
module axis_stream_checker
  import axis_checker_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FRAME_LEN  = 16,
  parameter int                    NUM_FRAMES = 4,
  parameter logic [DATA_WIDTH-1:0] SEED       = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  input  logic                 s00_axis_enable,
  input  logic                 s00_axis_clear,
  axis_stream_checker_if.slave s00_axis,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 error_flag,
  output logic                 done,
  output state_t               state_dbg
);

  localparam int                    IDX_W       = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]  FINAL_FRAME = CNT_WIDTH'(NUM_FRAMES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATA_WIDTH-1:0]  expected;
  logic [IDX_W-1:0]       beat_idx;
  logic                   accept;
  logic                   at_last_idx;
  logic                   frame_end;
  logic [ERR_NUM-1:0]     err_vec;
  logic [1:0]             err_num;

  // tready comes from registered state only, so dropping enable pauses mid-frame
  assign s00_axis.tready = (state == ST_RUN) && s00_axis_enable;

  // clear wins over a same-cycle handshake: that beat is dropped entirely
  assign accept      = s00_axis.tvalid && s00_axis.tready && !s00_axis_clear;
  assign at_last_idx = (beat_idx == LAST_IDX);
  assign frame_end   = accept && (s00_axis.tlast || at_last_idx);

  always_comb begin
    err_vec = '0;
    if (accept) begin
      err_vec[ERR_DATA] = (s00_axis.tdata != expected);
      err_vec[ERR_STRB] = (s00_axis.tstrb != '1);
      err_vec[ERR_LAST] = (s00_axis.tlast != at_last_idx);
    end
  end

  assign err_num = {1'b0, err_vec[ERR_DATA]} + {1'b0, err_vec[ERR_STRB]}
                 + {1'b0, err_vec[ERR_LAST]};

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (s00_axis_clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (s00_axis_enable) state_nxt = ST_RUN;
        ST_RUN:  if (frame_end && (frame_count == FINAL_FRAME)) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // On a match tdata equals expected, so tdata+1 covers both the normal
  // advance and the resync after a corrupt beat.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      expected   <= SEED;
      beat_idx   <= '0;
      error_flag <= 1'b0;
    end else if (s00_axis_clear) begin
      expected   <= SEED;
      beat_idx   <= '0;
      error_flag <= 1'b0;
    end else if (accept) begin
      expected <= s00_axis.tdata + DATA_WIDTH'(1);
      beat_idx <= frame_end ? '0 : beat_idx + IDX_W'(1);
      if (|err_vec) error_flag <= 1'b1;
    end
  end

  axis_checker_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_beat_cnt (
    .clk   (s00_axis_aclk),
    .rst   (s00_axis_areset),
    .clr   (s00_axis_clear),
    .inc   ({1'b0, accept}),
    .count (beat_count)
  );

  axis_checker_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk   (s00_axis_aclk),
    .rst   (s00_axis_areset),
    .clr   (s00_axis_clear),
    .inc   ({1'b0, frame_end}),
    .count (frame_count)
  );

  axis_checker_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_error_cnt (
    .clk   (s00_axis_aclk),
    .rst   (s00_axis_areset),
    .clr   (s00_axis_clear),
    .inc   (err_num),
    .count (error_count)
  );

  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Bench for axis_stream_checker: directed vector table, hand sequences for
// frame/clear/reset corners, and random traffic against a spec-level model.
module tb_axis_stream_checker;
  import axis_checker_pkg::*;

  localparam int DW         = 32;
  localparam int FRAME_LEN  = 16;
  localparam int NUM_FRAMES = 4;
  localparam int CW         = 16;
  localparam int CNT_MAX    = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic          clear  = 1'b0;
  logic [CW-1:0] beat_count, frame_count, error_count;
  logic          error_flag, done;
  state_t        state_dbg;

  axis_stream_checker_if #(.DATA_WIDTH(DW)) axis ();

  axis_stream_checker #(
    .DATA_WIDTH(DW), .FRAME_LEN(FRAME_LEN), .NUM_FRAMES(NUM_FRAMES),
    .SEED('0), .CNT_WIDTH(CW)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_enable (enable),
    .s00_axis_clear  (clear),
    .s00_axis        (axis),
    .beat_count      (beat_count),
    .frame_count     (frame_count),
    .error_count     (error_count),
    .error_flag      (error_flag),
    .done            (done),
    .state_dbg       (state_dbg)
  );

  // narrow counter instance so saturation is reachable quickly
  logic       sc_clr = 1'b0;
  logic [1:0] sc_inc = 2'd0;
  logic [3:0] sc_count;
  axis_checker_sat_counter #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .clr(sc_clr), .inc(sc_inc), .count(sc_count)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_started, m_done, m_flag;
  logic [31:0] m_exp;
  int          m_pos, m_beats, m_frames, m_errs;

  function automatic void model_reset();
    m_started = 0; m_done = 0; m_flag = 0;
    m_exp = '0; m_pos = 0; m_beats = 0; m_frames = 0; m_errs = 0;
  endfunction

  function automatic bit model_ready(input bit en);
    return m_started && !m_done && en;
  endfunction

  function automatic void model_update(input bit en, input bit clr, input bit valid,
                                       input logic [31:0] data, input logic [3:0] strb,
                                       input bit last);
    int e;
    bit end_pos;
    if (clr) begin model_reset(); return; end
    if (!m_started) begin m_started = en; return; end
    if (m_done || !(valid && en)) return;
    end_pos = (m_pos == FRAME_LEN - 1);
    e = 0;
    if (data !== m_exp) e++;
    if (strb !== 4'hF)  e++;
    if (last != end_pos) e++;
    m_exp   = data + 32'd1;
    m_beats = (m_beats + 1 > CNT_MAX) ? CNT_MAX : m_beats + 1;
    m_errs  = (m_errs + e > CNT_MAX) ? CNT_MAX : m_errs + e;
    if (e > 0) m_flag = 1;
    if (last || end_pos) begin
      m_pos = 0;
      m_frames++;
      if (m_frames == NUM_FRAMES) m_done = 1;
    end else begin
      m_pos++;
    end
  endfunction

  function automatic state_t model_state();
    return m_done ? ST_DONE : (m_started ? ST_RUN : ST_IDLE);
  endfunction

  task automatic check_outputs(input bit en);
    check("tready", 64'(axis.tready), 64'(model_ready(en)));
    check("beat_count", 64'(beat_count), 64'(m_beats));
    check("frame_count", 64'(frame_count), 64'(m_frames));
    check("error_count", 64'(error_count), 64'(m_errs));
    check("error_flag", 64'(error_flag), 64'(m_flag));
    check("done", 64'(done), 64'(m_done));
    check("state", 64'(state_dbg), 64'(model_state()));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit en, input bit clr, input bit valid,
                      input logic [31:0] data, input logic [3:0] strb, input bit last);
    enable = en; clear = clr;
    axis.tvalid = valid; axis.tdata = data; axis.tstrb = strb; axis.tlast = last;
    #2;
    check("tready_pre", 64'(axis.tready), 64'(model_ready(en)));
    @(posedge clk);
    model_update(en, clr, valid, data, strb, last);
    #1;
    check_outputs(en);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 0; clear = 0; axis.tvalid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame_seq(input int first, input int n, input int last_at);
    for (int k = 0; k < n; k++)
      step(1, 0, 1, 32'(first + k), 4'hF, k == last_at);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit en; bit clr; bit valid; logic [31:0] data; logic [3:0] strb; bit last;
    bit x_ready; int x_beats; int x_frames; int x_errs; bit x_flag; int x_state;
  } vec_t;
  vec_t vecs[11];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    axis.tvalid = 0; axis.tdata = '0; axis.tstrb = '0; axis.tlast = 0;
    model_reset();

    // reset state before any clock edge
    #1;
    check("rst_tready", 64'(axis.tready), 64'd0);
    check("rst_beats", 64'(beat_count), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_flag", 64'(error_flag), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    do_reset();

    //           en clr val data          strb  lst rdy beats frm errs flag state
    vecs[0]  = '{0, 0, 1, 32'h0,        4'hF, 0,  0,  0,   0,  0,   0,   0};
    vecs[1]  = '{1, 0, 1, 32'h0,        4'hF, 0,  0,  0,   0,  0,   0,   1};
    vecs[2]  = '{1, 0, 1, 32'h0,        4'hF, 0,  1,  1,   0,  0,   0,   1};
    vecs[3]  = '{1, 0, 1, 32'h1,        4'hF, 0,  1,  2,   0,  0,   0,   1};
    vecs[4]  = '{0, 0, 1, 32'h2,        4'hF, 0,  0,  2,   0,  0,   0,   1};
    vecs[5]  = '{1, 0, 1, 32'h2,        4'h7, 0,  1,  3,   0,  1,   1,   1};
    vecs[6]  = '{1, 0, 1, 32'h99,       4'hF, 0,  1,  4,   0,  2,   1,   1};
    vecs[7]  = '{1, 0, 1, 32'h9A,       4'hF, 0,  1,  5,   0,  2,   1,   1};
    vecs[8]  = '{1, 1, 1, 32'h9B,       4'hF, 0,  1,  0,   0,  0,   0,   0};
    vecs[9]  = '{1, 0, 0, 32'h0,        4'hF, 0,  0,  0,   0,  0,   0,   1};
    vecs[10] = '{1, 0, 1, 32'h0,        4'hF, 0,  1,  1,   0,  0,   0,   1};

    for (int i = 0; i < 11; i++) begin
      enable = vecs[i].en;
      #2;
      check("vec_ready", 64'(axis.tready), 64'(vecs[i].x_ready));
      step(vecs[i].en, vecs[i].clr, vecs[i].valid, vecs[i].data, vecs[i].strb, vecs[i].last);
      check("vec_beats", 64'(beat_count), 64'(vecs[i].x_beats));
      check("vec_frames", 64'(frame_count), 64'(vecs[i].x_frames));
      check("vec_errs", 64'(error_count), 64'(vecs[i].x_errs));
      check("vec_flag", 64'(error_flag), 64'(vecs[i].x_flag));
      check("vec_state", 64'(state_dbg), 64'(vecs[i].x_state));
    end

    // clean stream: four full frames
    do_reset();
    step(1, 0, 0, 0, 4'hF, 0);
    for (int k = 0; k < 64; k++) step(1, 0, 1, 32'(k), 4'hF, (k % 16) == 15);
    check("clean_beats", 64'(beat_count), 64'd64);
    check("clean_frames", 64'(frame_count), 64'd4);
    check("clean_errs", 64'(error_count), 64'd0);
    check("clean_done", 64'(done), 64'd1);
    step(1, 0, 1, 32'd64, 4'hF, 0);
    check("clean_ready_after", 64'(axis.tready), 64'd0);
    check("clean_beats_hold", 64'(beat_count), 64'd64);

    // corrupt beat with resync: beats after it continue from the bad value
    step(1, 1, 0, 0, 4'hF, 0);
    step(1, 0, 0, 0, 4'hF, 0);
    for (int k = 0; k < 16; k++)
      step(1, 0, 1, (k < 5) ? 32'(k) : 32'hDEAD + 32'(k - 5), 4'hF, k == 15);
    check("corrupt_errs", 64'(error_count), 64'd1);
    check("corrupt_flag", 64'(error_flag), 64'd1);
    check("corrupt_frames", 64'(frame_count), 64'd1);

    // early tlast at index 9, then a frame missing tlast at index 15
    step(1, 1, 0, 0, 4'hF, 0);
    step(1, 0, 0, 0, 4'hF, 0);
    send_frame_seq(0, 10, 9);
    check("early_errs", 64'(error_count), 64'd1);
    check("early_frames", 64'(frame_count), 64'd1);
    send_frame_seq(10, 16, -1);
    check("miss_errs", 64'(error_count), 64'd2);
    check("miss_frames", 64'(frame_count), 64'd2);

    // backpressure: enable toggles every 3 cycles, tvalid held high
    step(1, 1, 0, 0, 4'hF, 0);
    begin
      int k;
      int cyc;
      bit en;
      k = 0;
      cyc = 0;
      while (k < 64 && cyc < 400) begin
        en = ((cyc / 3) % 2) == 0;
        if (model_ready(en)) begin
          step(en, 0, 1, 32'(k), 4'hF, (k % 16) == 15);
          k++;
        end else begin
          step(en, 0, 1, 32'(k), 4'hF, (k % 16) == 15);
        end
        cyc++;
      end
      check("bp_completed", 64'(k), 64'd64);
    end
    check("bp_beats", 64'(beat_count), 64'd64);
    check("bp_frames", 64'(frame_count), 64'd4);
    check("bp_errs", 64'(error_count), 64'd0);
    check("bp_done", 64'(done), 64'd1);

    // strobe fault on a single beat
    step(1, 1, 0, 0, 4'hF, 0);
    step(1, 0, 0, 0, 4'hF, 0);
    step(1, 0, 1, 32'd0, 4'h7, 0);
    check("strb_errs", 64'(error_count), 64'd1);
    step(1, 0, 1, 32'd1, 4'hF, 0);
    check("strb_errs_hold", 64'(error_count), 64'd1);

    // async reset between edges at beat 7
    step(1, 1, 0, 0, 4'hF, 0);
    step(1, 0, 0, 0, 4'hF, 0);
    send_frame_seq(0, 7, -1);
    enable = 1; axis.tvalid = 1; axis.tdata = 32'd7;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_tready", 64'(axis.tready), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_beats", 64'(beat_count), 64'd0);
    check("arst_frames", 64'(frame_count), 64'd0);
    check("arst_state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 4'hF, 0);
    send_frame_seq(0, 16, 15);
    check("arst_resume_errs", 64'(error_count), 64'd0);
    check("arst_resume_frames", 64'(frame_count), 64'd1);

    // random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      bit en, clr, valid, last;
      logic [31:0] data;
      logic [3:0] strb;
      en    = $urandom_range(9, 0) < 8;
      clr   = ($urandom_range(99, 0) == 0) || (m_done && $urandom_range(3, 0) == 0);
      valid = $urandom_range(3, 0) != 0;
      data  = ($urandom_range(19, 0) == 0) ? 32'($urandom) : m_exp;
      strb  = ($urandom_range(29, 0) == 0) ? 4'($urandom_range(14, 0)) : 4'hF;
      last  = (m_pos == FRAME_LEN - 1);
      if ($urandom_range(24, 0) == 0) last = ~last;
      step(en, clr, valid, data, strb, last);
    end

    // saturating counter boundary
    @(negedge clk);
    sc_clr = 1; sc_inc = 2'd0;
    @(posedge clk); #1;
    check("sat_clr", 64'(sc_count), 64'd0);
    sc_clr = 0; sc_inc = 2'd3;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check("sat_inc3", 64'(sc_count), 64'((3 * i > 15) ? 15 : 3 * i));
    end
    sc_inc = 2'd1;
    @(posedge clk); #1;
    check("sat_hold", 64'(sc_count), 64'd15);
    sc_clr = 1; sc_inc = 2'd3;
    @(posedge clk); #1;
    check("sat_clr_prio", 64'(sc_count), 64'd0);
    sc_clr = 0; sc_inc = 2'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
